// File: rtl/alu_share_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_if
// Description : Request/response bundle between two ALU requesters and the
//               ALU share arbiter. Port 0 is the main execute stage, port 1
//               the auxiliary address/compare unit.
//               master : requester side (drives valid/opcode/operands and
//                        rsp ready, observes req ready and responses)
//               slave  : arbiter side
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_share_if #(
    parameter int XLEN = 32,
    parameter int OPW  = 4
);
    logic            req0_valid;
    logic            req0_ready;
    logic [OPW-1:0]  req0_opcode;
    logic [XLEN-1:0] req0_a;
    logic [XLEN-1:0] req0_b;

    logic            req1_valid;
    logic            req1_ready;
    logic [OPW-1:0]  req1_opcode;
    logic [XLEN-1:0] req1_a;
    logic [XLEN-1:0] req1_b;

    logic            rsp0_valid;
    logic            rsp0_ready;
    logic [XLEN-1:0] rsp0_result;

    logic            rsp1_valid;
    logic            rsp1_ready;
    logic [XLEN-1:0] rsp1_result;

    modport master (
        output req0_valid, req0_opcode, req0_a, req0_b,
        output req1_valid, req1_opcode, req1_a, req1_b,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp1_valid, rsp1_result
    );

    modport slave (
        input  req0_valid, req0_opcode, req0_a, req0_b,
        input  req1_valid, req1_opcode, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp1_valid, rsp1_result
    );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Time-shares one combinational integer ALU between two
//               requesters. Round-robin grant in IDLE, one EXEC cycle with
//               registered ALU operands, then the captured result is held in
//               RESP until the granted requester accepts it.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               bus (slave)       - request/response channels of both ports
//               alu_opcode/a/b    - registered ALU drive
//               alu_result        - combinational ALU output
//               busy              - high whenever not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int XLEN = 32,
    parameter int OPW  = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    alu_share_if.slave           bus,
    output logic [OPW-1:0]       alu_opcode,
    output logic [XLEN-1:0]      alu_a,
    output logic [XLEN-1:0]      alu_b,
    input  wire logic [XLEN-1:0] alu_result,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic            r_prio;       // port preferred on the next tie
    logic            r_gnt;        // port that owns the in-flight op
    logic [OPW-1:0]  r_alu_opcode;
    logic [XLEN-1:0] r_alu_a;
    logic [XLEN-1:0] r_alu_b;
    logic [XLEN-1:0] r_result;

    logic            w_ready0;
    logic            w_ready1;
    logic            w_accept;
    logic            w_rsp_fire;
    logic            w_rsp0_valid;
    logic            w_rsp1_valid;
    logic            w_busy;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)   w_next_state = S_EXEC;
            S_EXEC:                  w_next_state = S_RESP;
            S_RESP:  if (w_rsp_fire) w_next_state = S_IDLE;
            default:                 w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. The two ready terms are mutually exclusive: on a tie
    // only the port selected by r_prio sees ready.
    // ------------------------------------------------------------------
    always_comb begin
        w_ready0     = 1'b0;
        w_ready1     = 1'b0;
        w_rsp0_valid = 1'b0;
        w_rsp1_valid = 1'b0;
        w_busy       = 1'b1;
        w_rsp_fire   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy   = 1'b0;
                w_ready0 = bus.req0_valid & (~r_prio | ~bus.req1_valid);
                w_ready1 = bus.req1_valid & ( r_prio | ~bus.req0_valid);
            end
            S_RESP: begin
                w_rsp0_valid = ~r_gnt;
                w_rsp1_valid =  r_gnt;
                w_rsp_fire   = r_gnt ? bus.rsp1_ready : bus.rsp0_ready;
            end
            default: ;
        endcase
    end

    assign w_accept = w_ready0 | w_ready1;

    // ------------------------------------------------------------------
    // Datapath: ALU drive registers, grant/priority and result capture.
    // Operands are only sampled on the accept edge; they then hold until
    // the next acceptance so the ALU inputs stay quiet while idle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio       <= 1'b0;
            r_gnt        <= 1'b0;
            r_alu_opcode <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_result     <= '0;
        end else begin
            if (w_accept) begin
                r_gnt        <= w_ready1;
                r_prio       <= w_ready0;   // loser of this round goes first next
                r_alu_opcode <= w_ready1 ? bus.req1_opcode : bus.req0_opcode;
                r_alu_a      <= w_ready1 ? bus.req1_a      : bus.req0_a;
                r_alu_b      <= w_ready1 ? bus.req1_b      : bus.req0_b;
            end
            if (r_state == S_EXEC) begin
                r_result <= alu_result;
            end
        end
    end

    assign bus.req0_ready  = w_ready0;
    assign bus.req1_ready  = w_ready1;
    assign bus.rsp0_valid  = w_rsp0_valid;
    assign bus.rsp1_valid  = w_rsp1_valid;
    assign bus.rsp0_result = r_result;
    assign bus.rsp1_result = r_result;
    assign alu_opcode      = r_alu_opcode;
    assign alu_a           = r_alu_a;
    assign alu_b           = r_alu_b;
    assign busy            = w_busy;

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester arbiter and sequencer that time-shares the single combinational integer ALU between the main execute stage (port 0) and the auxiliary address/compare unit (port 1). Each requester hands over an ALU opcode and two operands on a valid/ready channel. The block grants one request at a time with round-robin fairness and drives the ALU from registered operands. It captures the result and returns it on a per-requester valid/ready response channel, holding it until the requester accepts it.

## Interface
- XLEN, 32: operand/result width.
- OPW, 4: ALU opcode width; matches the ALU opcode encoding (ADD=0001, SUB=0010, …, SLTU=1011).
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  port 0 request present.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_opcode  in  OPW  port 0 ALU opcode.
- req0_a, req0_b  in  XLEN  port 0 operands.
- req1_valid, req1_ready, req1_opcode, req1_a, req1_b: same for port 1.
- rsp0_valid  out  1  port 0 result available.
- rsp0_ready  in  1  port 0 consumes result.
- rsp0_result  out  XLEN  port 0 result.
- rsp1_valid, rsp1_ready, rsp1_result: same for port 1.
- alu_opcode  out  OPW  opcode to ALU (registered).
- alu_a, alu_b  out  XLEN  operands to ALU (registered).
- alu_result  in  XLEN  combinational ALU output.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req0_ready = valid0 & (prio==0 | !valid1).
  - req1_ready = valid1 & (prio==1 | !valid0).
  - At most one ready is high.
  - On acceptance, latch opcode/a/b into the ALU drive registers and the winner id into gnt; go to EXEC.
- EXEC: the ALU computes from the registered operands. At the end of the cycle, capture alu_result into the result register and go to RESP.
- RESP: rsp[gnt]_valid=1 with the held result, and the other rsp_valid=0. On rsp[gnt]_ready, go to IDLE. The result holds stable until then.
- prio: 1-bit round-robin pointer. On each acceptance it is set to the non-winning port (prio = ~gnt).
- No requests are accepted outside IDLE; both req_ready are 0 in EXEC/RESP.
- alu_opcode/alu_a/alu_b hold their last values after completion. The block never drives them combinationally from request inputs.
- Opcodes pass through unchecked; an undefined opcode yields whatever the ALU produces.
- Reset values: state=IDLE, prio=0, gnt=0, alu_opcode=4'b0000, alu_a=alu_b=0, result=0. All rsp_valid=0, busy=0, and all req_ready=0 unless a valid is present in IDLE.
- Reset mid-operation (EXEC or RESP): the in-flight op is dropped, no response is issued, and no partial result is visible after reset.

## Timing
- req_ready is combinational from state, prio and both req_valid. Requesters must not make req_valid depend on req_ready.
- Accept edge at cycle N; EXEC during N+1; rspX_valid is high from cycle N+2.
- Minimum occupancy is 3 cycles per op when rsp_ready is held high. Peak throughput is 1 op per 3 cycles.
- A response handshake at cycle M returns the FSM to IDLE at M+1. A new request can be accepted at M+1, with no combinational bypass from RESP to accept.
- Simultaneous valid0 & valid1 in IDLE: prio decides the winner. The loser keeps valid and is guaranteed service on the next IDLE cycle.
- rsp_ready held low stalls indefinitely in RESP; the result and valid stay stable.
- Requests arriving during EXEC/RESP wait with ready=0. Operands are sampled only on the accept edge.

## Test plan
- Single op, port 0 SUB: a=10, b=3, rsp0_ready=1 → req0_ready at N, alu_opcode=0010 at N+1, rsp0_valid with result 7 at N+2; rsp1_valid stays 0.
- Contention from reset (prio=0): both ports assert ADD (5+6) and XOR (0xF0^0x0F) continuously → port 0 served first (11), then port 1 (0xFF), then port 0 again; grants alternate strictly.
- Response backpressure: port 1 SLTU a=1, b=2, rsp1_ready low for 5 cycles → rsp1_valid=1 and result=1 held stable 5 cycles; req0 pending is not accepted until one cycle after the rsp1 handshake.
- Operand stability: change req0_a/req0_b the cycle after acceptance → the result reflects the values sampled at the accept edge only.
- Reset mid-op: assert rst during EXEC → next cycle state=IDLE, rsp0/1_valid=0, alu_opcode=0000, prio=0; a subsequent request completes normally.
- Idle ALU hold: after an op completes with no new requests → alu_opcode/alu_a/alu_b unchanged, busy=0, both req_ready=0.
